// File: rtl/nss_pkg.sv
// Shared sizing, state encoding and helpers for the nibble-serial subtractor.
// Consumed by nibble_serial_subtractor and nibble_sub_cell.
package nss_pkg;

   localparam int unsigned NSS_WIDTH     = 32;
   localparam int unsigned NSS_NIBBLE    = 4;
   localparam int unsigned NSS_NUM_STEPS = NSS_WIDTH / NSS_NIBBLE;

   // A single-slice build still needs a 1-bit counter to stay legal.
   function automatic int unsigned nss_step_w(input int unsigned steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   localparam int unsigned NSS_STEP_W = nss_step_w(NSS_NUM_STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nss_state_e;

endpackage

// File: rtl/nibble_sub_cell.sv
// Combinational NIBBLE-bit slice: a - b - borrow (or a + b + carry when NSS_ADD_MODE_EN
// is defined and op_add_i is set). The link bit is a borrow in subtract mode, a carry in add mode.
module nibble_sub_cell
   import nss_pkg::*;
#(
   parameter int unsigned NIBBLE = NSS_NIBBLE
) (
   input  logic [NIBBLE-1:0] a_i,
   input  logic [NIBBLE-1:0] b_i,
   input  logic              link_i,
`ifdef NSS_ADD_MODE_EN
   input  logic              op_add_i,
`endif
   output logic [NIBBLE-1:0] s_o,
   output logic              link_o
);

   logic [NIBBLE:0]   sum;
   logic [NIBBLE-1:0] b_eff;
   logic              cin;
   logic              add_mode;

   always_comb begin
`ifdef NSS_ADD_MODE_EN
      add_mode = op_add_i;
`else
      add_mode = 1'b0;
`endif
      // Subtract is add of the inverted subtrahend with an inverted borrow as carry-in.
      b_eff  = add_mode ? b_i : ~b_i;
      cin    = add_mode ? link_i : ~link_i;
      sum    = {1'b0, a_i} + {1'b0, b_eff} + {{NIBBLE{1'b0}}, cin};
      s_o    = sum[NIBBLE-1:0];
      link_o = add_mode ? sum[NIBBLE] : ~sum[NIBBLE];
   end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Sequential WIDTH-bit diff = a - b - bin, one NIBBLE slice per clock, start/busy/done handshake.
// Optional add mode (input op_add) enabled by defining NSS_ADD_MODE_EN.
module nibble_serial_subtractor
   import nss_pkg::*;
#(
   parameter int unsigned WIDTH  = NSS_WIDTH,
   parameter int unsigned NIBBLE = NSS_NIBBLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
`ifdef NSS_ADD_MODE_EN
   input  logic             op_add,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned NUM_STEPS = WIDTH / NIBBLE;
   localparam int unsigned STEP_W    = nss_step_w(NUM_STEPS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   nss_state_e        state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              link_q, link_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              bout_q, bout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;
   logic              add_q, add_d;

   logic [NIBBLE-1:0] slice_s;
   logic              slice_link;
   logic [WIDTH-1:0]  res_nxt;
   logic              accept;
   logic              msb_a, msb_b, msb_d;

   nibble_sub_cell #(
      .NIBBLE (NIBBLE)
   ) u_cell (
      .a_i      (a_q[step_q*NIBBLE +: NIBBLE]),
      .b_i      (b_q[step_q*NIBBLE +: NIBBLE]),
      .link_i   (link_q),
`ifdef NSS_ADD_MODE_EN
      .op_add_i (add_q),
`endif
      .s_o      (slice_s),
      .link_o   (slice_link)
   );

   always_comb begin
      res_nxt = res_q;
      res_nxt[step_q*NIBBLE +: NIBBLE] = slice_s;
   end

   assign msb_a = a_q[WIDTH-1];
   assign msb_b = b_q[WIDTH-1];
   assign msb_d = res_nxt[WIDTH-1];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      link_d  = link_q;
      step_d  = step_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      add_d   = add_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) accept = 1'b1;
         end
         RUN: begin
            res_d  = res_nxt;
            link_d = slice_link;
            step_d = step_q + STEP_W'(1);
            if (step_q == LAST_STEP) begin
               // Outputs change only here, so the partial result never reaches diff.
               state_d = DONE;
               diff_d  = res_nxt;
               bout_d  = slice_link;
               zero_d  = (res_nxt == '0);
               if (add_q) ovf_d = ~(msb_a ^ msb_b) & (msb_a ^ msb_d);
               else       ovf_d =  (msb_a ^ msb_b) & (msb_a ^ msb_d);
            end
         end
         DONE: begin
            if (start) accept  = 1'b1;
            else       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d = RUN;
         a_d     = a;
         b_d     = b;
         link_d  = bin;
         step_d  = '0;
         res_d   = '0;
`ifdef NSS_ADD_MODE_EN
         add_d   = op_add;
`else
         add_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         link_q  <= 1'b0;
         step_q  <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         add_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         link_q  <= link_d;
         step_q  <= step_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         add_q   <= add_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign diff     = diff_q;
   assign bout     = bout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed and random operations against an arithmetic model.
// Define NSS_ADD_MODE_EN to also exercise add mode.
module tb_nibble_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        bin = 1'b0;
   logic        op_add = 1'b0;
   logic        busy, done, bout, overflow, zero;
   logic [31:0] diff;

   int vectors = 0;
   int miscompares = 0;

   nibble_serial_subtractor dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .bin      (bin),
`ifdef NSS_ADD_MODE_EN
      .op_add   (op_add),
`endif
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .bout     (bout),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns {overflow, zero, bout, diff} from plain integer arithmetic.
   function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mbin, input logic madd);
      logic [32:0] full;
      longint      sa, sb, sr;
      logic        ovf;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (madd) begin
         full = {1'b0, ma} + {1'b0, mb} + {32'd0, mbin};
         sr   = sa + sb + longint'(mbin);
      end else begin
         full = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
         sr   = sa - sb - longint'(mbin);
      end
      ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {ovf, (full[31:0] == 32'd0), full[32], full[31:0]};
   endfunction

   task automatic check_result(input string tag, input logic [34:0] e);
      check({tag, ".diff"}, diff, e[31:0]);
      check({tag, ".bout"}, {31'd0, bout}, {31'd0, e[32]});
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, e[33]});
      check({tag, ".ovf"},  {31'd0, overflow}, {31'd0, e[34]});
   endtask

   // intrude=1 raises start with other operands mid-run; it must be ignored.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tbin, input logic tadd, input bit intrude);
      logic [34:0] e;
      e = model(ta, tb_, tbin, tadd);
      @(negedge clk);
      a = ta; b = tb_; bin = tbin; op_add = tadd; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (intrude && (k == 2 || k == 3)) begin
            start = 1'b1; a = ~ta; b = ta; bin = ~tbin; op_add = ~tadd;
         end else begin
            start = 1'b0;
         end
         check({tag, ".busy"}, {31'd0, busy}, 32'd1);
         check({tag, ".nodone"}, {31'd0, done}, 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      check({tag, ".done"}, {31'd0, done}, 32'd1);
      check({tag, ".busy_dn"}, {31'd0, busy}, 32'd0);
      check_result(tag, e);
      @(negedge clk);
      check({tag, ".pulse"}, {31'd0, done}, 32'd0);
      check({tag, ".idle"}, {31'd0, busy}, 32'd0);
      check_result({tag, ".hold"}, e);
   endtask

   initial begin
      logic [34:0] e1, e2;
      logic [31:0] ra, rb;
      logic        rbin, radd;

      #1;
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.diff", diff, 32'd0);
      check("rst.flags", {29'd0, bout, overflow, zero}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op("basic", 32'd10, 32'd3, 1'b0, 1'b0, 1'b0);
      run_op("under", 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
      run_op("ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b0);
      run_op("zero", 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
      run_op("zero_bin", 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
      run_op("ignore", 32'd100, 32'd30, 1'b0, 1'b0, 1'b1);

      // Abort mid-operation at step 4.
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h0000_1111; bin = 1'b0; op_add = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort.busy", {31'd0, busy}, 32'd0);
      check("abort.done", {31'd0, done}, 32'd0);
      check("abort.diff", diff, 32'd0);
      check("abort.flags", {29'd0, bout, overflow, zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("abort.nodone", {30'd0, done, busy}, 32'd0);
      end
      run_op("post_rst", 32'd9, 32'd4, 1'b0, 1'b0, 1'b0);

      // Back-to-back: start held through DONE accepts the next operation at once.
      e1 = model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
      e2 = model(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
      @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h0123_4567; bin = 1'b1; op_add = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a = 32'h0000_0010; b = 32'h0000_0020; bin = 1'b0;
         check("b2b.busy1", {31'd0, busy}, 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      check("b2b.done1", {31'd0, done}, 32'd1);
      check_result("b2b.r1", e1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("b2b.noidle", {30'd0, busy, done}, 32'd2);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         if (k < 7) begin
            @(negedge clk);
            check("b2b.busy2", {31'd0, busy}, 32'd1);
         end
      end
      @(negedge clk);
      check("b2b.done2", {31'd0, done}, 32'd1);
      check_result("b2b.r2", e2);

`ifdef NSS_ADD_MODE_EN
      run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
      run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
      run_op("add_cin", 32'd20, 32'd22, 1'b1, 1'b1, 1'b0);
`endif

      for (int i = 0; i < 16; i++) begin
         ra   = $urandom;
         rb   = (i % 4 == 0) ? ra : $urandom;
         rbin = 1'($urandom_range(0, 1));
`ifdef NSS_ADD_MODE_EN
         radd = 1'($urandom_range(0, 1));
`else
         radd = 1'b0;
`endif
         run_op("rand", ra, rb, rbin, radd, (i % 5 == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
